hp_vpu_scoreboard: RTL and testbench

Per-register pending-write scoreboard for the Hyperplane VPU. It is the producer side of RAW hazard tracking: the issue stage records each destination write when it is accepted, and writeback retires it. The block holds one saturating in-flight counter per vector register and gates issue with a RAW-hazard and capacity check against the D2 instruction's sources. It also reports per-register busy state, a total in-flight count and pipeline idle to the VPU top and the scalar-core interface.

---
 rtl/hp_vpu_scoreboard_if.sv | 71 +++++++
 rtl/hp_vpu_scoreboard.sv | 181 ++++++++++++++++++
 tb/tb_hp_vpu_scoreboard.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hp_vpu_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hp_vpu_scoreboard_if
//
// Purpose: groups the D2 issue handshake, writeback retire and flush signals
// exchanged between the VPU issue stage (master) and the pending-write
// scoreboard (slave).
//
// Signals:
//   d_valid_i      D2 holds a candidate instruction
//   d_vs1_i/2/3    D2 source registers (vs3 is the MAC accumulator)
//   d_src_use_i    source-valid mask: bit0 vs1, bit1 vs2, bit2 vs3
//   d_wr_i         D2 instruction writes d_vd_i
//   d_vd_i         D2 destination register
//   issue_fire_i   D2 instruction leaves D2 this cycle
//   issue_ready_o  no hazard and destination counter not saturated
//   raw_hazard_o   a used source has a pending write
//   wb_valid_i     writeback retires one write
//   wb_vd_i        writeback destination register
//   kill_i         pipeline flush from the scalar core
// ---------------------------------------------------------------------------
interface hp_vpu_scoreboard_if;

    logic       d_valid_i;
    logic [4:0] d_vs1_i;
    logic [4:0] d_vs2_i;
    logic [4:0] d_vs3_i;
    logic [2:0] d_src_use_i;
    logic       d_wr_i;
    logic [4:0] d_vd_i;
    logic       issue_fire_i;
    logic       issue_ready_o;
    logic       raw_hazard_o;
    logic       wb_valid_i;
    logic [4:0] wb_vd_i;
    logic       kill_i;

    // Issue stage / writeback side
    modport master (
        output d_valid_i,
        output d_vs1_i,
        output d_vs2_i,
        output d_vs3_i,
        output d_src_use_i,
        output d_wr_i,
        output d_vd_i,
        output issue_fire_i,
        input  issue_ready_o,
        input  raw_hazard_o,
        output wb_valid_i,
        output wb_vd_i,
        output kill_i
    );

    // Scoreboard side
    modport slave (
        input  d_valid_i,
        input  d_vs1_i,
        input  d_vs2_i,
        input  d_vs3_i,
        input  d_src_use_i,
        input  d_wr_i,
        input  d_vd_i,
        input  issue_fire_i,
        output issue_ready_o,
        output raw_hazard_o,
        input  wb_valid_i,
        input  wb_vd_i,
        input  kill_i
    );

endinterface

// File: rtl/hp_vpu_scoreboard.sv
// ---------------------------------------------------------------------------
// hp_vpu_scoreboard
//
// Purpose: per-register pending-write scoreboard for the Hyperplane VPU.
// Each vector register owns a saturating in-flight counter. Accepted issues
// that write a register increment its counter, writebacks decrement it. The
// D2 instruction is gated by a RAW-hazard check on its used sources and a
// capacity check on its destination counter.
//
// Build option:
//   HP_VPU_SB_WB_BYPASS_EN  when defined, a register whose counter is 1 and
//                           that is being written back this cycle is treated
//                           as already released by the hazard and full
//                           checks (not in a kill cycle). State update rules
//                           are identical in both builds.
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   sb          issue / writeback / kill handshake (slave modport)
//   busy_o      bit r set while register r has an outstanding write
//   inflight_o  total outstanding writes
//   idle_o      no outstanding writes at all
//   err_o       sticky protocol error (underflow or issue while not ready)
// ---------------------------------------------------------------------------
module hp_vpu_scoreboard #(
    parameter int unsigned NUM_VREGS = 32,
    parameter int unsigned CNT_W     = 3,
    parameter int unsigned TOT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hp_vpu_scoreboard_if.slave    sb,
    output logic [NUM_VREGS-1:0]  busy_o,
    output logic [TOT_W-1:0]      inflight_o,
    output logic                  idle_o,
    output logic                  err_o
);

`ifdef HP_VPU_SB_WB_BYPASS_EN
    localparam bit WbBypass = 1'b1;
`else
    localparam bit WbBypass = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [TOT_W-1:0] TotOne  = TOT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt [NUM_VREGS];
    logic [TOT_W-1:0] r_tot;
    logic             r_err;

    logic [CNT_W-1:0] w_cnt_nxt [NUM_VREGS];
    logic [TOT_W-1:0] w_tot_nxt;
    logic             w_err_nxt;

    // ------------------------------------------------------------------
    // Per-register status
    // ------------------------------------------------------------------
    logic [NUM_VREGS-1:0] w_busy;   // cnt != 0
    logic [NUM_VREGS-1:0] w_rel;    // released early by a same-cycle writeback
    logic [NUM_VREGS-1:0] w_pend;   // busy as seen by the hazard check
    logic [NUM_VREGS-1:0] w_sat;    // saturated as seen by the capacity check
    logic [NUM_VREGS-1:0] w_inc;
    logic [NUM_VREGS-1:0] w_dec;

    always_comb begin
        w_busy = '0;
        w_rel  = '0;
        w_pend = '0;
        w_sat  = '0;
        for (int unsigned r = 0; r < NUM_VREGS; r++) begin
            w_busy[r] = (r_cnt[r] != '0);
            // Bypass only releases the final outstanding write; a kill
            // discards the writeback so it cannot release anything.
            w_rel[r]  = WbBypass && sb.wb_valid_i && !sb.kill_i &&
                        (sb.wb_vd_i == 5'(r)) && (r_cnt[r] == CntOne);
            w_pend[r] = w_busy[r] && !w_rel[r];
            w_sat[r]  = (r_cnt[r] == CntMax) && !w_rel[r];
        end
    end

    // ------------------------------------------------------------------
    // Hazard and issue gating
    // ------------------------------------------------------------------
    logic w_src_hit;
    logic w_full;
    logic w_ready;

    always_comb begin
        w_src_hit = (sb.d_src_use_i[0] && w_pend[sb.d_vs1_i]) ||
                    (sb.d_src_use_i[1] && w_pend[sb.d_vs2_i]) ||
                    (sb.d_src_use_i[2] && w_pend[sb.d_vs3_i]);
        w_full    = sb.d_wr_i && w_sat[sb.d_vd_i];
        w_ready   = sb.d_valid_i && !(sb.d_valid_i && w_src_hit) && !w_full;
    end

    assign sb.raw_hazard_o  = sb.d_valid_i && w_src_hit;
    assign sb.issue_ready_o = w_ready;

    // ------------------------------------------------------------------
    // Update qualification; everything arriving with kill_i is dropped,
    // including any error it would otherwise raise.
    // ------------------------------------------------------------------
    logic w_iss_ok;
    logic w_iss_bad;
    logic w_wb_ok;
    logic w_wb_bad;

    always_comb begin
        w_iss_ok  = sb.issue_fire_i && w_ready && sb.d_wr_i && !sb.kill_i;
        w_iss_bad = sb.issue_fire_i && !w_ready && !sb.kill_i;
        w_wb_ok   = sb.wb_valid_i && w_busy[sb.wb_vd_i] && !sb.kill_i;
        w_wb_bad  = sb.wb_valid_i && !w_busy[sb.wb_vd_i] && !sb.kill_i;
    end

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int unsigned r = 0; r < NUM_VREGS; r++) begin
            w_inc[r] = w_iss_ok && (sb.d_vd_i == 5'(r));
            w_dec[r] = w_wb_ok && (sb.wb_vd_i == 5'(r));
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        w_tot_nxt = r_tot;
        w_err_nxt = r_err || w_iss_bad || w_wb_bad;
        for (int unsigned r = 0; r < NUM_VREGS; r++) begin
            w_cnt_nxt[r] = r_cnt[r];
            if (sb.kill_i) begin
                w_cnt_nxt[r] = '0;
            end else if (w_inc[r] && !w_dec[r] && (r_cnt[r] != CntMax)) begin
                w_cnt_nxt[r] = r_cnt[r] + CntOne;
            end else if (w_dec[r] && !w_inc[r] && (r_cnt[r] != '0)) begin
                w_cnt_nxt[r] = r_cnt[r] - CntOne;
            end
        end
        // An issue and a writeback in the same cycle cancel in the total,
        // whether or not they target the same register.
        if (sb.kill_i) begin
            w_tot_nxt = '0;
        end else if (w_iss_ok && !w_wb_ok) begin
            w_tot_nxt = r_tot + TotOne;
        end else if (w_wb_ok && !w_iss_ok) begin
            w_tot_nxt = r_tot - TotOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_VREGS; r++) begin
                r_cnt[r] <= '0;
            end
            r_tot <= '0;
            r_err <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_VREGS; r++) begin
                r_cnt[r] <= w_cnt_nxt[r];
            end
            r_tot <= w_tot_nxt;
            r_err <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Status outputs: registered state only
    // ------------------------------------------------------------------
    assign busy_o     = w_busy;
    assign inflight_o = r_tot;
    assign idle_o     = (r_tot == '0);
    assign err_o      = r_err;

endmodule

// File: tb/tb_hp_vpu_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hp_vpu_scoreboard
//
// Self-checking bench for hp_vpu_scoreboard. Expected status words
// {busy, inflight, idle, err} are queued when stimulus is driven and popped
// and compared one cycle later. Combinational hazard/ready are checked
// inline before the clock edge.
// ---------------------------------------------------------------------------
module tb_hp_vpu_scoreboard;

`ifdef HP_VPU_SB_WB_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hp_vpu_scoreboard_if sb_if ();

    logic [31:0] busy;
    logic [7:0]  infl;
    logic        idle;
    logic        err;

    hp_vpu_scoreboard #(
        .NUM_VREGS (32),
        .CNT_W     (3),
        .TOT_W     (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sb         (sb_if),
        .busy_o     (busy),
        .inflight_o (infl),
        .idle_o     (idle),
        .err_o      (err)
    );

    typedef struct {
        string       name;
        logic [41:0] st;
    } exp_t;

    typedef struct {
        bit          iss;
        logic [4:0]  ivd;
        bit          wb;
        logic [4:0]  wvd;
        logic [31:0] b;
        logic [7:0]  n;
        string       name;
    } step_t;

    exp_t exp_q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;

    function automatic logic [41:0] st(input logic [31:0] b, input logic [7:0] n,
                                       input logic er);
        return {b, n, (n == 8'd0), er};
    endfunction

    function automatic logic [41:0] obs();
        return {busy, infl, idle, err};
    endfunction

    task automatic clr_in();
        sb_if.d_valid_i    = 1'b0;
        sb_if.d_vs1_i      = '0;
        sb_if.d_vs2_i      = '0;
        sb_if.d_vs3_i      = '0;
        sb_if.d_src_use_i  = '0;
        sb_if.d_wr_i       = 1'b0;
        sb_if.d_vd_i       = '0;
        sb_if.issue_fire_i = 1'b0;
        sb_if.wb_valid_i   = 1'b0;
        sb_if.wb_vd_i      = '0;
        sb_if.kill_i       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sb_if.issue_fire_i = 1'b0;
        sb_if.wb_valid_i   = 1'b0;
        sb_if.kill_i       = 1'b0;
    endtask

    task automatic issue(input logic [4:0] vd);
        sb_if.d_valid_i    = 1'b1;
        sb_if.d_wr_i       = 1'b1;
        sb_if.d_vd_i       = vd;
        sb_if.d_src_use_i  = 3'b000;
        sb_if.issue_fire_i = 1'b1;
    endtask

    task automatic wb(input logic [4:0] vd);
        sb_if.wb_valid_i = 1'b1;
        sb_if.wb_vd_i    = vd;
    endtask

    task automatic push(input string name, input logic [41:0] s);
        exp_t x;
        x.name = name;
        x.st   = s;
        exp_q.push_back(x);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        clr_in();
        #2;
        total++;
        if (obs() !== st(32'h0, 8'd0, 1'b0)) begin
            bad++;
            $display("FAIL reset_state: got %h required %h", obs(), st(32'h0, 8'd0, 1'b0));
        end
        sb_if.d_valid_i = 1'b1;
        #1;
        total++;
        if ({sb_if.raw_hazard_o, sb_if.issue_ready_o} !== 2'b01) begin
            bad++;
            $display("FAIL reset_ready_v1: got %b required 01",
                     {sb_if.raw_hazard_o, sb_if.issue_ready_o});
        end
        sb_if.d_valid_i = 1'b0;
        #1;
        total++;
        if ({sb_if.raw_hazard_o, sb_if.issue_ready_o} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready_v0: got %b required 00",
                     {sb_if.raw_hazard_o, sb_if.issue_ready_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_raw_basic();
        issue(5'd5);
        push("issue_v5", st(32'h0000_0020, 8'd1, 1'b0));
        tick();
        e = exp_q.pop_front(); total++;
        if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
        sb_if.d_wr_i      = 1'b0;
        sb_if.d_vs1_i     = 5'd5;
        sb_if.d_src_use_i = 3'b001;
        #1;
        total++;
        if ({sb_if.raw_hazard_o, sb_if.issue_ready_o} !== 2'b10) begin
            bad++;
            $display("FAIL raw_v5: got %b required 10", {sb_if.raw_hazard_o, sb_if.issue_ready_o});
        end
        wb(5'd5);
        #1;
        total++;
        if ({sb_if.raw_hazard_o, sb_if.issue_ready_o} !== {!Byp, Byp}) begin
            bad++;
            $display("FAIL raw_wb_cycle: got %b required %b",
                     {sb_if.raw_hazard_o, sb_if.issue_ready_o}, {!Byp, Byp});
        end
        push("wb_v5", st(32'h0, 8'd0, 1'b0));
        tick();
        e = exp_q.pop_front(); total++;
        if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
        total++;
        if ({sb_if.raw_hazard_o, sb_if.issue_ready_o} !== 2'b01) begin
            bad++;
            $display("FAIL raw_released: got %b required 01",
                     {sb_if.raw_hazard_o, sb_if.issue_ready_o});
        end
        clr_in();
    endtask

    // ------------------------------------------------------------------
    task automatic test_full();
        for (int i = 1; i <= 7; i++) begin
            issue(5'd3);
            push("fill_v3", st(32'h0000_0008, 8'(i), 1'b0));
            tick();
            e = exp_q.pop_front(); total++;
            if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
        end
        #1;
        total++;
        if ({sb_if.raw_hazard_o, sb_if.issue_ready_o} !== 2'b00) begin
            bad++;
            $display("FAIL full_v3: got %b required 00", {sb_if.raw_hazard_o, sb_if.issue_ready_o});
        end
        wb(5'd3);
        #1;
        total++;
        if (sb_if.issue_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL full_wb_cycle: got %b required 0", sb_if.issue_ready_o);
        end
        push("drain_v3", st(32'h0000_0008, 8'd6, 1'b0));
        tick();
        e = exp_q.pop_front(); total++;
        if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
        total++;
        if (sb_if.issue_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL full_released: got %b required 1", sb_if.issue_ready_o);
        end
        clr_in();
        sb_if.kill_i = 1'b1;
        push("full_cleanup_kill", st(32'h0, 8'd0, 1'b0));
        tick();
        e = exp_q.pop_front(); total++;
        if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_same_cycle();
        step_t tbl[6];
        tbl[0] = '{1'b1, 5'd7,  1'b0, 5'd0,  32'h0000_0080, 8'd1, "sc_iss7_a"};
        tbl[1] = '{1'b1, 5'd7,  1'b0, 5'd0,  32'h0000_0080, 8'd2, "sc_iss7_b"};
        tbl[2] = '{1'b1, 5'd7,  1'b1, 5'd7,  32'h0000_0080, 8'd2, "sc_iss7_wb7"};
        tbl[3] = '{1'b1, 5'd10, 1'b1, 5'd7,  32'h0000_0480, 8'd2, "sc_iss10_wb7"};
        tbl[4] = '{1'b0, 5'd0,  1'b1, 5'd7,  32'h0000_0400, 8'd1, "sc_wb7"};
        tbl[5] = '{1'b0, 5'd0,  1'b1, 5'd10, 32'h0000_0000, 8'd0, "sc_wb10"};
        foreach (tbl[i]) begin
            if (tbl[i].iss) issue(tbl[i].ivd);
            if (tbl[i].wb) wb(tbl[i].wvd);
            push(tbl[i].name, st(tbl[i].b, tbl[i].n, 1'b0));
            tick();
            e = exp_q.pop_front(); total++;
            if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
        end
        clr_in();
    endtask

    // ------------------------------------------------------------------
    task automatic test_mask();
        issue(5'd8);
        push("mask_iss8", st(32'h0000_0100, 8'd1, 1'b0));
        tick();
        e = exp_q.pop_front(); total++;
        if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
        sb_if.d_wr_i      = 1'b0;
        sb_if.d_vs1_i     = 5'd0;
        sb_if.d_vs2_i     = 5'd1;
        sb_if.d_vs3_i     = 5'd8;
        sb_if.d_src_use_i = 3'b011;
        #1;
        total++;
        if ({sb_if.raw_hazard_o, sb_if.issue_ready_o} !== 2'b01) begin
            bad++;
            $display("FAIL mask_vs3_off: got %b required 01", {sb_if.raw_hazard_o, sb_if.issue_ready_o});
        end
        sb_if.d_src_use_i = 3'b111;
        #1;
        total++;
        if ({sb_if.raw_hazard_o, sb_if.issue_ready_o} !== 2'b10) begin
            bad++;
            $display("FAIL mask_vs3_on: got %b required 10", {sb_if.raw_hazard_o, sb_if.issue_ready_o});
        end
        clr_in();
        sb_if.kill_i = 1'b1;
        push("mask_cleanup_kill", st(32'h0, 8'd0, 1'b0));
        tick();
        e = exp_q.pop_front(); total++;
        if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_underflow();
        wb(5'd9);
        push("underflow_v9", st(32'h0, 8'd0, 1'b1));
        tick();
        e = exp_q.pop_front(); total++;
        if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
        for (int i = 0; i < 3; i++) begin
            push("err_sticky", st(32'h0, 8'd0, 1'b1));
            tick();
            e = exp_q.pop_front(); total++;
            if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_kill();
        issue(5'd1);
        push("kill_iss1", st(32'h0000_0002, 8'd1, 1'b1));
        tick();
        e = exp_q.pop_front(); total++;
        if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
        issue(5'd2);
        push("kill_iss2", st(32'h0000_0006, 8'd2, 1'b1));
        tick();
        e = exp_q.pop_front(); total++;
        if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
        issue(5'd4);
        push("kill_iss4", st(32'h0000_0016, 8'd3, 1'b1));
        tick();
        e = exp_q.pop_front(); total++;
        if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
        issue(5'd6);
        wb(5'd1);
        sb_if.kill_i = 1'b1;
        push("kill_flush", st(32'h0, 8'd0, 1'b1));
        tick();
        e = exp_q.pop_front(); total++;
        if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
        clr_in();
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset();
        issue(5'd12);
        push("ar_iss12", st(32'h0000_1000, 8'd1, 1'b1));
        tick();
        e = exp_q.pop_front(); total++;
        if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs() !== st(32'h0, 8'd0, 1'b0)) begin
            bad++;
            $display("FAIL async_reset: got %h required %h", obs(), st(32'h0, 8'd0, 1'b0));
        end
        clr_in();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        issue(5'd5);
        push("b2b_iss5", st(32'h0000_0020, 8'd1, 1'b0));
        tick();
        e = exp_q.pop_front(); total++;
        if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
        // Consumer of v5 writing v6 tries to issue in v5's writeback cycle.
        issue(5'd6);
        sb_if.d_vs1_i     = 5'd5;
        sb_if.d_src_use_i = 3'b001;
        wb(5'd5);
        #1;
        total++;
        if (sb_if.issue_ready_o !== Byp) begin
            bad++;
            $display("FAIL b2b_ready: got %b required %b", sb_if.issue_ready_o, Byp);
        end
        if (Byp) push("b2b_fire", st(32'h0000_0040, 8'd1, 1'b0));
        else     push("b2b_fire", st(32'h0, 8'd0, 1'b1));
        tick();
        e = exp_q.pop_front(); total++;
        if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
        clr_in();
        sb_if.kill_i = 1'b1;
        push("b2b_cleanup_kill", st(32'h0, 8'd0, !Byp));
        tick();
        e = exp_q.pop_front(); total++;
        if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_illegal_fire();
        sb_if.d_valid_i    = 1'b0;
        sb_if.d_wr_i       = 1'b1;
        sb_if.d_vd_i       = 5'd2;
        sb_if.issue_fire_i = 1'b1;
        push("illegal_fire", st(32'h0, 8'd0, 1'b1));
        tick();
        e = exp_q.pop_front(); total++;
        if (obs() !== e.st) begin bad++; $display("FAIL %s: got %h required %h", e.name, obs(), e.st); end
        clr_in();
    endtask

    initial begin
        test_reset();
        test_raw_basic();
        test_full();
        test_same_cycle();
        test_mask();
        test_underflow();
        test_kill();
        test_async_reset();
        test_back_to_back();
        test_illegal_fire();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
